// File: rtl/alu_mdu.sv
// alu_mdu: RV32I ALU plus iterative RV32M multiply/divide behind start/valid.
// Define ALU_MDU_FAST_MUL_EN for a single-cycle combinational multiplier.
module alu_mdu #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             md_sel,
  input  logic [3:0]       alu_fun,
  input  logic [2:0]       md_fun,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [WIDTH-1:0] DEAD = WIDTH'(16'hdead);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q;
  logic [SHW-1:0]     cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [2:0]         fun_q;
  logic               neg_q;
  logic               sa_q;
  logic               busy_q;
  logic               valid_q;
  logic [WIDTH-1:0]   res_q;

  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] base_res;

  assign sh = srcB[SHW-1:0];

  always_comb begin
    base_res = '0;
    unique case (alu_fun)
      4'b0000: base_res = srcA + srcB;
      4'b1000: base_res = srcA - srcB;
      4'b0110: base_res = srcA | srcB;
      4'b0111: base_res = srcA & srcB;
      4'b0100: base_res = srcA ^ srcB;
      4'b0101: base_res = srcA >> sh;
      4'b0001: base_res = srcA << sh;
      4'b1101: base_res = $signed(srcA) >>> sh;
      4'b0010: base_res = {{(WIDTH-1){1'b0}}, $signed(srcA) < $signed(srcB)};
      4'b0011: base_res = {{(WIDTH-1){1'b0}}, srcA < srcB};
      4'b1001: base_res = srcA;
      default: base_res = DEAD;
    endcase
  end

  // Operand signedness per M op; mul (low half) is sign-agnostic.
  logic is_div, a_sgn, b_sgn, sa, sb, div0, ovf;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign is_div = md_fun[2];
  assign a_sgn  = is_div ? ~md_fun[0]
                : (md_fun[1:0] == 2'b01) || (md_fun[1:0] == 2'b10);
  assign b_sgn  = is_div ? ~md_fun[0] : (md_fun[1:0] == 2'b01);
  assign sa     = a_sgn & srcA[WIDTH-1];
  assign sb     = b_sgn & srcB[WIDTH-1];
  assign mag_a  = sa ? -srcA : srcA;
  assign mag_b  = sb ? -srcB : srcB;
  assign div0   = (srcB == '0);
  assign ovf    = ~md_fun[0] & (srcA == MINV) & (&srcB);

  logic [WIDTH-1:0] mul_fast;
`ifdef ALU_MDU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
  logic [2*WIDTH-1:0] fprod;
  assign fprod = {{WIDTH{sa}}, srcA} * {{WIDTH{sb}}, srcB};
  assign mul_fast = (md_fun[1:0] == 2'b00) ? fprod[WIDTH-1:0]
                                           : fprod[2*WIDTH-1:WIDTH];
`else
  localparam bit FAST_MUL = 1'b0;
  assign mul_fast = '0;
`endif

  logic             md_fast;
  logic [WIDTH-1:0] fast_res;

  assign md_fast  = is_div ? (div0 | ovf) : FAST_MUL;
  assign fast_res = !is_div ? mul_fast
                  : div0    ? (md_fun[1] ? srcA : '1)
                  :           (md_fun[1] ? '0 : srcA);

  // Shift-add multiply step: multiplier sits in the low half.
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mul_nxt;
  assign msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, dvs_q} : '0);
  assign mul_nxt = {msum, acc_q[WIDTH-1:1]};

  // Restoring divide step: remainder high, quotient shifts in low.
  logic [WIDTH:0]     dsh, ddif;
  logic               dge;
  logic [2*WIDTH-1:0] div_nxt;
  assign dsh     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign ddif    = dsh - {1'b0, dvs_q};
  assign dge     = ~ddif[WIDTH];
  assign div_nxt = {dge ? ddif[WIDTH-1:0] : dsh[WIDTH-1:0],
                    acc_q[WIDTH-2:0], dge};

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s, rem_s, done_res;
  assign prod_s = neg_q ? -acc_q : acc_q;
  assign quot_s = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_s  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    done_res = '0;
    unique case (fun_q)
      3'b000:                 done_res = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: done_res = prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         done_res = quot_s;
      default:                done_res = rem_s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      fun_q   <= '0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (!md_sel) begin
              res_q   <= base_res;
              valid_q <= 1'b1;
            end else if (md_fast) begin
              res_q   <= fast_res;
              valid_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              state_q <= CALC;
              cnt_q   <= SHW'(WIDTH-1);
              fun_q   <= md_fun;
              neg_q   <= sa ^ sb;
              sa_q    <= sa;
              acc_q   <= {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
              dvs_q   <= is_div ? mag_b : mag_a;
            end
          end
        end
        CALC: begin
          acc_q <= fun_q[2] ? div_nxt : mul_nxt;
          cnt_q <= cnt_q - SHW'(1);
          if (cnt_q == '0) state_q <= DONE;
        end
        DONE: begin
          res_q   <= done_res;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign valid  = valid_q;
  assign result = res_q;

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, sequential successor to the single-cycle Otter ALU.
- Executes all base RV32I ALU operations plus the RV32M multiply/divide group behind a start/valid handshake.
- Base ops complete in one cycle. MUL/DIV ops run iteratively over WIDTH cycles.
- Sits in the execute stage; the control unit stalls on busy.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an even value ≥ 8.
- SHW, $clog2(WIDTH), shift-amount bit count taken from srcB (derived; do not override).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; srcA/srcB/alu_fun/md_sel/md_fun are sampled with it.
- md_sel  in  1  0 = base ALU op (alu_fun), 1 = M-extension op (md_fun).
- alu_fun  in  4  base op: 0000 add, 1000 sub, 0110 or, 0111 and, 0100 xor, 0101 srl, 0001 sll, 1101 sra, 0010 slt, 0011 sltu, 1001 lui (pass srcA).
- md_fun  in  3  000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- srcA  in  WIDTH  operand A (rs1 for M ops).
- srcB  in  WIDTH  operand B (rs2 for M ops).
- busy  out  1  iterative operation in progress; start is ignored while high.
- valid  out  1  one-cycle pulse: result is updated this cycle.
- result  out  WIDTH  registered result; holds until the next valid.

Behaviour:
- Reset: state IDLE; busy=0, valid=0, result=0, iteration counter=0. Reset mid-operation aborts it and produces no valid.
- States: IDLE, CALC, DONE.
- IDLE and start with md_sel=0:
  - result is registered from the base op; valid=1 next cycle; state stays IDLE.
  - Latency is 1.
- Base-op rules:
  - Shift amount is srcB[SHW-1:0].
  - slt/sltu produce zero-extended 0/1.
  - Illegal alu_fun produces 'hdead zero-extended to WIDTH.
- IDLE and start with md_sel=1, fast-path cases (complete in 1 cycle like base ops, no CALC):
  - Divide by zero: div/divu give all-ones; rem/remu give srcA.
  - Signed overflow (srcA = most-negative, srcB = -1): div gives srcA; rem gives 0.
- Otherwise for md_sel=1: latch operands (converted to magnitudes for signed forms, with sign flags), set busy=1, then go to CALC.
- CALC:
  - One shift-add (mul) or one restoring shift-subtract (div) step per cycle, WIDTH steps, with the counter counting WIDTH-1 down to 0.
  - The 2*WIDTH product accumulator is internal.
  - Divide uses a WIDTH-bit remainder plus a carry bit.
- DONE:
  - Apply sign correction: product negated if operand signs differ; quotient likewise; remainder takes the dividend's sign.
  - Select the result field: mul = low WIDTH bits, mulh* = high WIDTH bits, div* = quotient, rem* = remainder.
  - Register result; valid=1, busy=0; return to IDLE.
- Timing, with start in cycle 0:
  - busy is high in cycles 1..WIDTH+1.
  - valid and the new result appear in cycle WIDTH+2, which is cycle 34 for WIDTH=32.
- Back-to-back: start is accepted in the same cycle valid is high. Start while busy=1 is dropped silently, and its operands are not latched.
- Operand changes after start have no effect on the in-flight op.
- valid is never high for two consecutive cycles from a single start.

Optional Feature:
- Macro: ALU_MDU_FAST_MUL_EN.
- Defined: the four multiply ops use a combinational WIDTH×WIDTH signed/unsigned multiplier with 1-cycle latency, identical in timing to base ops, and never assert busy. Divide remains iterative.
- Undefined: all multiplies use the iterative CALC path with latency WIDTH+2.
- Numeric results are identical either way.

Test Plan:
- Base ops, WIDTH=32:
  - start, md_sel=0, alu_fun=1101, srcA=32'h8000_0000, srcB=32'h0000_0024 → cycle 1: valid=1, result=32'hF800_0000 (shift 4).
  - alu_fun=1111 → result=32'h0000_DEAD.
- Signed multiply:
  - mulh with srcA=-2, srcB=3 → result=32'hFFFF_FFFF in cycle 34 (cycle 1 with ALU_MDU_FAST_MUL_EN).
  - mul with the same operands → 32'hFFFF_FFFA.
- Divide edge cases:
  - div srcA=-7, srcB=2 → result=-3 (32'hFFFF_FFFD).
  - rem with the same operands → -1.
  - divu srcA=7, srcB=0 → 32'hFFFF_FFFF in cycle 1.
  - rem with srcA=32'h8000_0000, srcB=-1 → 0 in cycle 1, busy never high.
- Handshake:
  - Issue divu 100/7; pulse start with other operands in cycle 5 → ignored; cycle 34: result=14, single valid pulse.
  - New start in cycle 34 is accepted.
- Reset mid-operation: assert rst in cycle 10 of a div → next cycle busy=0, valid=0, result=0; no later valid.
- Random regression: 10k random ops per md_fun/alu_fun against a reference model, WIDTH=32 and WIDTH=16, both macro settings; compare result at each valid.
